// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Pipeline control for the 3-stage core (IF | DE/EX | MEM/WB).
//   - Tracks the instruction currently sitting in MEM/WB.
//   - Produces the 2-bit forwarding selects for the DE-stage operand muxes.
//   - Produces stall/flush for the IF/DE register. This includes holding the
//     pipe while a MEM/WB data-memory access waits for dmem_ack. The access is
//     aborted after WAIT_MAX wait cycles.
//
// Parameters
//   WAIT_MAX    max WAIT cycles before a MEM/WB access is aborted (>= 1)
//   CNT_W       wait-counter width, 2**CNT_W > WAIT_MAX
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   de_valid            DE holds a live instruction
//   de_rs1/de_rs2       DE source register addresses
//   de_rs1_used/_used   DE instruction actually reads rs1/rs2
//   de_rd, de_reg_wr    DE destination register and write flag
//   de_wb_sel           DE writeback source (00 ALU, 01 load, 10 PC+4, 11 -> ALU)
//   de_mem_req          DE instruction is a load/store
//   de_br_taken         DE branch/jump resolved taken
//   dmem_ack            data memory completes the MEM/WB access this cycle
//   fwd_a_sel/fwd_b_sel operand mux selects (00 RF, 01 ALU, 10 load, 11 PC+4)
//   stall_if, stall_de  hold PC / hold IF/DE register
//   flush_de            load a bubble into IF/DE at the next edge
//   mw_valid, mw_rd     MEM/WB tracking outputs
//   mw_reg_wr           MEM/WB regfile write enable, dropped on abort
//   mem_err             one-cycle pulse when a MEM/WB access times out
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de_valid,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       de_rs1_used,
    input  logic       de_rs2_used,
    input  logic [4:0] de_rd,
    input  logic       de_reg_wr,
    input  logic [1:0] de_wb_sel,
    input  logic       de_mem_req,
    input  logic       de_br_taken,
    input  logic       dmem_ack,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall_if,
    output logic       stall_de,
    output logic       flush_de,
    output logic       mw_valid,
    output logic [4:0] mw_rd,
    output logic       mw_reg_wr,
    output logic       mem_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             mw_valid_q;
    logic [4:0]       mw_rd_q;
    logic             mw_reg_wr_q;
    logic [1:0]       mw_wb_sel_q;
    logic             mw_mem_req_q;

    logic             mw_pend;
    logic             stall;
    logic             aborting;
    logic             reg_wr_eff;

    // Maps a source operand onto the forwarding select. A hit needs a live,
    // writing MEM/WB instruction whose rd matches a non-x0 source that is
    // actually read. The select encodes the writeback source, and the
    // illegal wb_sel 11 is treated as the ALU result.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic       valid,
        input logic       wr,
        input logic [4:0] rd,
        input logic [1:0] wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (rs != 5'd0) && valid && wr && (rd == rs)) begin
            case (wb)
                2'b01:   sel = 2'b10;
                2'b10:   sel = 2'b11;
                default: sel = 2'b01;
            endcase
        end
        return sel;
    endfunction

    assign mw_pend    = mw_valid_q & mw_mem_req_q & ~dmem_ack;
    assign aborting   = (state == ST_ABORT);
    assign reg_wr_eff = mw_reg_wr_q & ~aborting;

    // Memory-wait controller. RUN enters WAIT when the MEM/WB access is not
    // acked. WAIT counts stalled cycles and gives up into ABORT once the
    // counter reaches WAIT_MAX. ABORT releases the pipe for exactly one
    // cycle, and the aborted instruction is dropped because that cycle does
    // not stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            ST_RUN: begin
                if (mw_pend) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_ONE;
                    stall     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_ABORT;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            ST_ABORT: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MEM/WB tracking registers. They advance with the pipe and freeze while
    // it is stalled. A taken branch advances too, because only the
    // instruction behind it in IF/DE is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mw_valid_q   <= 1'b0;
            mw_rd_q      <= 5'd0;
            mw_reg_wr_q  <= 1'b0;
            mw_wb_sel_q  <= 2'b00;
            mw_mem_req_q <= 1'b0;
        end else if (!stall) begin
            mw_valid_q   <= de_valid;
            mw_rd_q      <= de_rd;
            mw_reg_wr_q  <= de_reg_wr;
            mw_wb_sel_q  <= de_wb_sel;
            mw_mem_req_q <= de_mem_req;
        end
    end

    // Every output is forced low while reset is held. The registers may still
    // hold stale contents during the first reset cycle.
    assign stall_if  = stall & ~rst;
    assign stall_de  = stall & ~rst;
    assign flush_de  = de_valid & de_br_taken & ~stall & ~rst;
    assign mw_valid  = mw_valid_q & ~rst;
    assign mw_rd     = rst ? 5'd0 : mw_rd_q;
    assign mw_reg_wr = reg_wr_eff & ~rst;
    assign mem_err   = aborting & ~rst;

    assign fwd_a_sel = rst ? 2'b00 :
                       fwd_sel(de_rs1_used, de_rs1, mw_valid_q, reg_wr_eff, mw_rd_q, mw_wb_sel_q);
    assign fwd_b_sel = rst ? 2'b00 :
                       fwd_sel(de_rs2_used, de_rs2, mw_valid_q, reg_wr_eff, mw_rd_q, mw_wb_sel_q);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Self-checking bench for fwd_hazard_ctrl. The DUT is built with a short
// timeout so that the abort path is reached quickly. The bench runs in two
// phases:
//   1. A directed cycle-by-cycle table with hand-derived expected outputs.
//   2. Randomized traffic compared against a transaction-level reference
//      model.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    localparam int WMAX  = 4;
    localparam int NRAND = 400;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] wb;
        logic       mreq;
        logic       br;
        logic       ack;
    } in_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sif;
        logic       sde;
        logic       fl;
        logic       mv;
        logic [4:0] mrd;
        logic       mwr;
        logic       merr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       de_valid;
    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       de_rs1_used;
    logic       de_rs2_used;
    logic [4:0] de_rd;
    logic       de_reg_wr;
    logic [1:0] de_wb_sel;
    logic       de_mem_req;
    logic       de_br_taken;
    logic       dmem_ack;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall_if;
    logic       stall_de;
    logic       flush_de;
    logic       mw_valid;
    logic [4:0] mw_rd;
    logic       mw_reg_wr;
    logic       mem_err;

    int nChecks = 0;
    int nPass   = 0;

    vec_t vecs[$];

    // Reference model state. This is a transaction view of the pipeline: the
    // instruction in MEM/WB, how many cycles its access has stalled, and
    // whether the next cycle is the abort cycle.
    logic       mValid;
    logic [4:0] mRd;
    logic       mWr;
    logic [1:0] mWb;
    logic       mMreq;
    int         mWaited;
    bit         mAbort;

    fwd_hazard_ctrl #(
        .WAIT_MAX (WMAX),
        .CNT_W    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .de_valid    (de_valid),
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_rs1_used (de_rs1_used),
        .de_rs2_used (de_rs2_used),
        .de_rd       (de_rd),
        .de_reg_wr   (de_reg_wr),
        .de_wb_sel   (de_wb_sel),
        .de_mem_req  (de_mem_req),
        .de_br_taken (de_br_taken),
        .dmem_ack    (dmem_ack),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_if    (stall_if),
        .stall_de    (stall_de),
        .flush_de    (flush_de),
        .mw_valid    (mw_valid),
        .mw_rd       (mw_rd),
        .mw_reg_wr   (mw_reg_wr),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    function automatic in_t mkIn(
        input logic       r,
        input logic       dv,
        input logic [4:0] rs1,
        input logic       u1,
        input logic [4:0] rs2,
        input logic       u2,
        input logic [4:0] rd,
        input logic       wr,
        input logic [1:0] wb,
        input logic       mreq,
        input logic       br,
        input logic       ack
    );
        in_t v;
        v.rst = r;    v.dv = dv;     v.rs1 = rs1; v.u1 = u1;
        v.rs2 = rs2;  v.u2 = u2;     v.rd = rd;   v.wr = wr;
        v.wb = wb;    v.mreq = mreq; v.br = br;   v.ack = ack;
        return v;
    endfunction

    function automatic out_t mkOut(
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       stall,
        input logic       fl,
        input logic       mv,
        input logic [4:0] mrd,
        input logic       mwr,
        input logic       merr
    );
        out_t v;
        v.fa = fa;   v.fb = fb;   v.sif = stall; v.sde = stall;
        v.fl = fl;   v.mv = mv;   v.mrd = mrd;   v.mwr = mwr;
        v.merr = merr;
        return v;
    endfunction

    task automatic addVec(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    // Drives one cycle's worth of DE/memory inputs.
    task automatic applyStimulus(input in_t i);
        rst         = i.rst;
        de_valid    = i.dv;
        de_rs1      = i.rs1;
        de_rs1_used = i.u1;
        de_rs2      = i.rs2;
        de_rs2_used = i.u2;
        de_rd       = i.rd;
        de_reg_wr   = i.wr;
        de_wb_sel   = i.wb;
        de_mem_req  = i.mreq;
        de_br_taken = i.br;
        dmem_ack    = i.ack;
    endtask

    // Compares every DUT output against the expected record in a single check.
    task automatic checkOutput(input string name, input int idx, input out_t exp);
        out_t act;
        act.fa = fwd_a_sel;   act.fb = fwd_b_sel;
        act.sif = stall_if;   act.sde = stall_de;
        act.fl = flush_de;    act.mv = mw_valid;
        act.mrd = mw_rd;      act.mwr = mw_reg_wr;
        act.merr = mem_err;
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s[%0d]: got fa=%b fb=%b stall=%b%b flush=%b mv=%b rd=%0d wr=%b err=%b, want fa=%b fb=%b stall=%b%b flush=%b mv=%b rd=%0d wr=%b err=%b",
                     name, idx,
                     act.fa, act.fb, act.sif, act.sde, act.fl, act.mv, act.mrd, act.mwr, act.merr,
                     exp.fa, exp.fb, exp.sif, exp.sde, exp.fl, exp.mv, exp.mrd, exp.mwr, exp.merr);
        end
    endtask

    // Forwarding select computed from the writeback source. The select is one
    // above wb_sel, and the illegal code 3 behaves like the ALU result (0).
    function automatic logic [1:0] modelSel(input logic used, input logic [4:0] rs, input logic wrEff);
        int code;
        if (used && rs != 5'd0 && mValid && wrEff && mRd == rs) begin
            code = (mWb == 2'd3) ? 1 : int'(mWb) + 1;
            return 2'(code);
        end
        return 2'b00;
    endfunction

    function automatic logic modelStall(input in_t i);
        return !mAbort && mValid && mMreq && !i.ack;
    endfunction

    function automatic out_t modelOut(input in_t i);
        logic wrEff;
        logic st;
        if (i.rst) return mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        wrEff = mWr && !mAbort;
        st    = modelStall(i);
        return mkOut(modelSel(i.u1, i.rs1, wrEff), modelSel(i.u2, i.rs2, wrEff),
                     st, i.dv && i.br && !st, mValid, mRd, wrEff, mAbort);
    endfunction

    // Advances the model across one clock edge.
    task automatic modelStep(input in_t i);
        if (i.rst) begin
            mValid = 1'b0; mRd = 5'd0; mWr = 1'b0; mWb = 2'b00; mMreq = 1'b0;
            mWaited = 0;   mAbort = 1'b0;
        end else if (modelStall(i)) begin
            mWaited++;
            if (mWaited == WMAX + 1) mAbort = 1'b1;
        end else begin
            mValid = i.dv; mRd = i.rd; mWr = i.wr; mWb = i.wb; mMreq = i.mreq;
            mWaited = 0;   mAbort = 1'b0;
        end
    endtask

    initial begin
        in_t  cur;
        out_t exp;
        out_t zero;

        zero = mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset, then ADD x5 enters MEM/WB.
        addVec(mkIn(1,1,5'd5,1,5'd5,1,5'd5,1,2'd0,0,1,0), zero);
        addVec(mkIn(1,0,5'd0,0,5'd0,0,5'd0,0,2'd0,0,0,0), zero);
        addVec(mkIn(0,1,5'd0,0,5'd0,0,5'd5,1,2'd0,0,0,0), zero);
        // ADD x5 forwards to both operands. LW x7 enters.
        addVec(mkIn(0,1,5'd5,1,5'd5,1,5'd7,1,2'd1,1,0,0), mkOut(2'd1,2'd1,0,0,1,5'd5,1,0));
        // LW x7 is acked immediately and forwards load data to B. A taken JAL x1 flushes.
        addVec(mkIn(0,1,5'd0,1,5'd7,1,5'd1,1,2'd2,0,1,1), mkOut(2'd0,2'd2,0,1,1,5'd7,1,0));
        // JAL x1 forwards PC+4 to A. An x0-writer enters.
        addVec(mkIn(0,1,5'd1,1,5'd0,0,5'd0,1,2'd0,0,0,0), mkOut(2'd3,2'd0,0,0,1,5'd1,1,0));
        // rs==x0 never forwards even with rd==0. A store enters.
        addVec(mkIn(0,1,5'd0,1,5'd0,1,5'd0,0,2'd0,1,0,0), mkOut(2'd0,2'd0,0,0,1,5'd0,1,0));
        // Store waits 3 cycles with a taken branch in DE, then is acked.
        for (int k = 0; k < 3; k++)
            addVec(mkIn(0,1,5'd0,0,5'd0,0,5'd3,1,2'd0,0,1,0), mkOut(2'd0,2'd0,1,0,1,5'd0,0,0));
        addVec(mkIn(0,1,5'd0,0,5'd0,0,5'd3,1,2'd0,0,1,1), mkOut(2'd0,2'd0,0,1,1,5'd0,0,0));
        // Branch (rd=3) forwards ALU. LW x9 enters.
        addVec(mkIn(0,1,5'd3,1,5'd3,0,5'd9,1,2'd1,1,0,0), mkOut(2'd1,2'd0,0,0,1,5'd3,1,0));
        // LW x9 never acked: WMAX+1 stall cycles with load forwarding, then abort.
        for (int k = 0; k < WMAX + 1; k++)
            addVec(mkIn(0,1,5'd9,1,5'd9,1,5'd4,1,2'd0,0,0,0), mkOut(2'd2,2'd2,1,0,1,5'd9,1,0));
        addVec(mkIn(0,1,5'd9,1,5'd9,1,5'd4,1,2'd0,0,0,0), mkOut(2'd0,2'd0,0,0,1,5'd9,0,1));
        // Back in RUN with x4 in MEM/WB. A store enters.
        addVec(mkIn(0,1,5'd4,1,5'd0,0,5'd0,0,2'd0,1,0,0), mkOut(2'd1,2'd0,0,0,1,5'd4,1,0));
        // Store waits 2 cycles, then reset is pulsed mid-WAIT.
        for (int k = 0; k < 2; k++)
            addVec(mkIn(0,1,5'd0,0,5'd0,0,5'd6,1,2'd0,0,1,0), mkOut(2'd0,2'd0,1,0,1,5'd0,0,0));
        addVec(mkIn(1,1,5'd0,0,5'd0,0,5'd6,1,2'd0,0,1,0), zero);
        addVec(mkIn(0,0,5'd0,1,5'd0,1,5'd0,0,2'd0,0,1,0), zero);
        addVec(mkIn(0,1,5'd0,0,5'd0,0,5'd2,1,2'd0,0,0,0), zero);
        addVec(mkIn(0,1,5'd2,1,5'd0,0,5'd0,0,2'd0,0,0,0), mkOut(2'd1,2'd0,0,0,1,5'd2,1,0));

        applyStimulus(mkIn(1,0,5'd0,0,5'd0,0,5'd0,0,2'd0,0,0,0));
        @(posedge clk);
        #1;

        $display("[TB] directed table: %0d cycles", vecs.size());
        foreach (vecs[n]) begin
            applyStimulus(vecs[n].i);
            #3;
            checkOutput("directed", n, vecs[n].o);
            @(posedge clk);
            #1;
        end

        $display("[TB] randomized phase: %0d cycles", NRAND);
        for (int n = 0; n < NRAND; n++) begin
            cur.rst  = (n == 0) || ($urandom_range(0, 39) == 0);
            cur.dv   = ($urandom_range(0, 7) != 0);
            cur.rs1  = 5'($urandom_range(0, 3));
            cur.u1   = 1'($urandom_range(0, 1));
            cur.rs2  = 5'($urandom_range(0, 3));
            cur.u2   = 1'($urandom_range(0, 1));
            cur.rd   = 5'($urandom_range(0, 3));
            cur.wr   = ($urandom_range(0, 3) != 0);
            cur.wb   = 2'($urandom_range(0, 3));
            cur.mreq = ($urandom_range(0, 2) == 0);
            cur.br   = ($urandom_range(0, 4) == 0);
            cur.ack  = ($urandom_range(0, 3) == 0);
            exp = modelOut(cur);
            applyStimulus(cur);
            #3;
            checkOutput("random", n, exp);
            @(posedge clk);
            modelStep(cur);
            #1;
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
